// File: rtl/wb_ram_arbiter_pkg.sv
// ============================================================================
// wb_ram_arbiter_pkg : shared Wishbone widths, CTI/BTE codes, arbiter states
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_ram_arbiter_pkg;

  localparam int c_ADR_W = 32;
  localparam int c_DAT_W = 32;
  localparam int c_SEL_W = 4;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_CONST   = 3'b001;
  localparam logic [2:0] c_CTI_INCR    = 3'b010;
  localparam logic [2:0] c_CTI_END     = 3'b111;

  localparam logic [1:0] c_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] c_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] c_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] c_BTE_WRAP16  = 2'b11;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_rr_pick.sv
// ============================================================================
// wb_rr_pick : combinational rotating-priority picker with optional m0 priority
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_rr_pick #(
  parameter int NUM_M = 3,
  localparam int c_IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0]   req,
  input  logic [c_IDX_W-1:0] last,
  input  logic               prio0,
  output logic [NUM_M-1:0]   win,
  output logic               valid
);

  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;

  // Scan upward starting just after the previous owner.
  always_comb begin
    win     = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (prio0 && req[0]) begin
      win[0] = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_M; k++) begin
        w_idx = c_IDX_W'((int'(last) + k) % NUM_M);
        if (!w_found && req[w_idx]) begin
          win[w_idx] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
// ============================================================================
// wb_ram_arbiter : shares one Wishbone RAM slave between NUM_M masters with
//                  whole-cycle grants and a stall watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int NUM_M   = 3,
  parameter int PRIO0   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [c_ADR_W*NUM_M-1:0]   m_adr_i,
  input  logic [c_DAT_W*NUM_M-1:0]   m_dat_i,
  input  logic [c_SEL_W*NUM_M-1:0]   m_sel_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M-1:0]           m_cyc_i,
  input  logic [NUM_M-1:0]           m_stb_i,
  input  logic [3*NUM_M-1:0]         m_cti_i,
  input  logic [2*NUM_M-1:0]         m_bte_i,
  output logic [c_DAT_W-1:0]         m_dat_o,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [NUM_M-1:0]           m_err_o,
  output logic [c_ADR_W-1:0]         s_adr_o,
  output logic [c_DAT_W-1:0]         s_dat_o,
  output logic [c_SEL_W-1:0]         s_sel_o,
  output logic                       s_we_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic [c_DAT_W-1:0]         s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  output logic [NUM_M-1:0]           grant_o,
  output logic                       timeout_o
);

  localparam int c_IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int c_WD_W  = $clog2(TIMEOUT + 1);

  logic [0:0]         r_state;
  logic [NUM_M-1:0]   r_grant;
  logic [c_IDX_W-1:0] r_last;
  logic [c_WD_W-1:0]  r_wdog;

  logic [NUM_M-1:0]   w_win;
  logic               w_win_valid;
  logic [c_IDX_W-1:0] w_gidx;
  logic [c_ADR_W-1:0] w_adr;
  logic [c_DAT_W-1:0] w_dat;
  logic [c_SEL_W-1:0] w_sel;
  logic [2:0]         w_cti;
  logic [1:0]         w_bte;
  logic               w_we, w_cyc, w_stb;
  logic               w_busy, w_stall, w_abort, w_leave;

  wb_rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req   (m_cyc_i),
    .last  (r_last),
    .prio0 (PRIO0 != 0),
    .win   (w_win),
    .valid (w_win_valid)
  );

  // AND-OR mux on the one-hot grant; an empty grant yields all-zero slave signals.
  always_comb begin
    w_gidx = '0;
    w_adr  = '0;
    w_dat  = '0;
    w_sel  = '0;
    w_cti  = '0;
    w_bte  = '0;
    w_we   = 1'b0;
    w_cyc  = 1'b0;
    w_stb  = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (r_grant[k]) begin
        w_gidx = c_IDX_W'(k);
        w_adr  = w_adr | m_adr_i[k*c_ADR_W +: c_ADR_W];
        w_dat  = w_dat | m_dat_i[k*c_DAT_W +: c_DAT_W];
        w_sel  = w_sel | m_sel_i[k*c_SEL_W +: c_SEL_W];
        w_cti  = w_cti | m_cti_i[k*3 +: 3];
        w_bte  = w_bte | m_bte_i[k*2 +: 2];
        w_we   = w_we  | m_we_i[k];
        w_cyc  = w_cyc | m_cyc_i[k];
        w_stb  = w_stb | m_stb_i[k];
      end
    end
  end

  assign w_busy  = (r_state == c_ST_BUSY);
  assign w_stall = w_busy && w_stb && !s_ack_i && !s_err_i;
  assign w_abort = w_stall && (r_wdog == c_WD_W'(TIMEOUT - 1));
  assign w_leave = w_busy && (!w_cyc || w_abort);

  assign s_adr_o   = w_adr;
  assign s_dat_o   = w_dat;
  assign s_sel_o   = w_sel;
  assign s_cti_o   = w_cti;
  assign s_bte_o   = w_bte;
  assign s_we_o    = w_we;
  assign s_cyc_o   = w_busy && w_cyc && !w_abort;
  assign s_stb_o   = w_busy && w_stb && !w_abort;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = w_busy ? (r_grant & {NUM_M{s_ack_i}}) : '0;
  assign m_err_o   = w_busy ? (r_grant & {NUM_M{s_err_i | w_abort}}) : '0;
  assign grant_o   = r_grant;
  assign timeout_o = w_abort;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_ST_IDLE;
      r_grant <= '0;
      r_last  <= c_IDX_W'(NUM_M - 1);
      r_wdog  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_win_valid) begin
            r_state <= c_ST_BUSY;
            r_grant <= w_win;
          end
        end
        c_ST_BUSY: begin
          if (w_leave) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_last  <= w_gidx;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase

      // Saturating stall counter; any response or leaving BUSY restarts it.
      if (!w_busy || w_leave || s_ack_i || s_err_i) begin
        r_wdog <= '0;
      end else if (w_stall && (r_wdog != {c_WD_W{1'b1}})) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  a_busy_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == c_ST_BUSY) |-> $onehot(r_grant));

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
// ============================================================================
// tb_wb_ram_arbiter : directed stimulus with a queue-based response scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  localparam int NM = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i;
  logic [32*NM-1:0]  m_adr_i, m_dat_i;
  logic [4*NM-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [3*NM-1:0]   m_cti_i;
  logic [2*NM-1:0]   m_bte_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]        s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, timeout_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;

  logic [31:0] adr_m [NM];
  logic [31:0] dat_m [NM];
  logic [2:0]  cti_m [NM];

  always_comb begin
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    for (int k = 0; k < NM; k++) begin
      m_adr_i[32*k +: 32] = adr_m[k];
      m_dat_i[32*k +: 32] = dat_m[k];
      m_sel_i[4*k +: 4]   = 4'hF;
      m_cti_i[3*k +: 3]   = cti_m[k];
      m_bte_i[2*k +: 2]   = c_BTE_LINEAR;
    end
  end

  wb_ram_arbiter #(.NUM_M(NM), .PRIO0(1), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic        tmo;
    logic        scyc;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } resp_t;

  resp_t      exp_q [$];
  logic [2:0] exp_g [$];

  task automatic exp_resp(input logic [2:0] ack, input logic [2:0] err, input logic tmo,
                          input logic scyc, input logic [31:0] adr, input logic [2:0] cti,
                          input logic we, input logic [31:0] dat);
    resp_t r;
    r.ack = ack; r.err = err; r.tmo = tmo; r.scyc = scyc;
    r.adr = adr; r.cti = cti; r.we = we; r.dat = dat;
    exp_q.push_back(r);
  endtask

  initial begin : monitor
    logic [2:0] prev_g;
    logic [2:0] g;
    resp_t r;
    prev_g = '0;
    forever begin
      @(negedge clk_i);
      if (grant_o !== prev_g) begin
        if (exp_g.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected: got %b, no change required", grant_o);
        end else begin
          g = exp_g.pop_front();
          chk("grant_seq", 32'(grant_o), 32'(g));
        end
        prev_g = grant_o;
      end
      if ((m_ack_o != '0) || (m_err_o != '0) || timeout_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: ack=%b err=%b tmo=%b, none required",
                   m_ack_o, m_err_o, timeout_o);
        end else begin
          r = exp_q.pop_front();
          chk("m_ack",   32'(m_ack_o),   32'(r.ack));
          chk("m_err",   32'(m_err_o),   32'(r.err));
          chk("timeout", 32'(timeout_o), 32'(r.tmo));
          chk("s_cyc",   32'(s_cyc_o),   32'(r.scyc));
          chk("s_adr",   s_adr_o,        r.adr);
          chk("s_cti",   32'(s_cti_o),   32'(r.cti));
          chk("s_we",    32'(s_we_o),    32'(r.we));
          if (r.we) chk("s_dat", s_dat_o, r.dat);
          else      chk("m_dat", m_dat_o, r.dat);
        end
      end
    end
  end

  // ---------------- slave model: data = adr ^ DEADBEEF ----------------
  int slv_lat  = 1;
  int slv_mode = 0;   // 0 ack, 1 never respond, 2 err
  initial begin : slave
    int wcnt;
    wcnt = 0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    forever begin
      @(posedge clk_i); #2;
      if (s_cyc_o && s_stb_o) begin
        s_dat_i = s_adr_o ^ 32'hDEADBEEF;
        if (s_ack_i || s_err_i || slv_mode == 1) begin
          s_ack_i = 1'b0; s_err_i = 1'b0;
        end else if (wcnt >= slv_lat) begin
          wcnt = 0;
          if (slv_mode == 2) s_err_i = 1'b1;
          else               s_ack_i = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0; wcnt = 0;
      end
    end
  end

  // ---------------- master helpers ----------------
  task automatic wait_ack(input int k, output logic was_err);
    int   n;
    logic got;
    n = 0; got = 1'b0; was_err = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk_i);
      n++;
      if (m_ack_o[k] || m_err_o[k]) begin
        got = 1'b1;
        was_err = m_err_o[k];
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL wait_ack_m%0d: no ack/err after 60 cycles, one required", k);
    end
  endtask

  task automatic mxfer(input int k, input logic we, input logic [31:0] adr,
                       input int beats, input int hold);
    logic       e;
    logic [2:0] own;
    own = 3'(1 << k);
    @(posedge clk_i); #1;
    m_cyc_i[k] = 1'b1;
    m_we_i[k]  = we;
    for (int b = 0; b < beats; b++) begin
      adr_m[k]   = adr + 32'(4 * b);
      dat_m[k]   = {16'hC0DE, adr_m[k][15:0]};
      cti_m[k]   = (beats == 1) ? c_CTI_CLASSIC : ((b == beats - 1) ? c_CTI_END : c_CTI_INCR);
      m_stb_i[k] = 1'b1;
      wait_ack(k, e);
      @(posedge clk_i); #1;
      if (e) break;
    end
    m_stb_i[k] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("hold_grant", 32'(grant_o), 32'(own));
      @(posedge clk_i); #1;
    end
    m_cyc_i[k] = 1'b0;
    m_we_i[k]  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, finish required");
    $fatal(1, "global timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic e;
    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    for (int k = 0; k < NM; k++) begin
      adr_m[k] = '0; dat_m[k] = '0; cti_m[k] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("rst_grant",   32'(grant_o),   0);
    chk("rst_s_cyc",   32'(s_cyc_o),   0);
    chk("rst_s_stb",   32'(s_stb_o),   0);
    chk("rst_s_we",    32'(s_we_o),    0);
    chk("rst_s_adr",   s_adr_o,        0);
    chk("rst_s_dat",   s_dat_o,        0);
    chk("rst_s_sel",   32'(s_sel_o),   0);
    chk("rst_s_cti",   32'(s_cti_o),   0);
    chk("rst_s_bte",   32'(s_bte_o),   0);
    chk("rst_m_ack",   32'(m_ack_o),   0);
    chk("rst_m_err",   32'(m_err_o),   0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_m_dat",   m_dat_o,        0);

    // Single m1 read, slave acks after 2 clk.
    slv_lat = 2; slv_mode = 0;
    exp_g.push_back(3'b010); exp_g.push_back(3'b000);
    exp_resp(3'b010, 3'b000, 1'b0, 1'b1, 32'h0, c_CTI_CLASSIC, 1'b0, 32'hDEADBEEF);
    fork
      mxfer(1, 1'b0, 32'h0, 1, 0);
      begin
        @(posedge clk_i);
        @(negedge clk_i);
        chk("arb_lat_idle",  32'(grant_o), 0);
        chk("arb_lat_scyc",  32'(s_cyc_o), 0);
        @(negedge clk_i);
        chk("arb_lat_grant", 32'(grant_o), 32'(3'b010));
      end
    join
    repeat (2) @(posedge clk_i);

    // m1 and m2 together from last=2: m1, dead cycle, m2.
    pulse_reset();
    slv_lat = 1;
    exp_g.push_back(3'b010); exp_g.push_back(3'b000);
    exp_g.push_back(3'b100); exp_g.push_back(3'b000);
    exp_resp(3'b010, 3'b000, 1'b0, 1'b1, 32'h10, c_CTI_CLASSIC, 1'b0, 32'hDEADBEFF);
    exp_resp(3'b100, 3'b000, 1'b0, 1'b1, 32'h20, c_CTI_CLASSIC, 1'b0, 32'hDEADBECF);
    fork
      mxfer(1, 1'b0, 32'h10, 1, 0);
      mxfer(2, 1'b0, 32'h20, 1, 0);
    join
    repeat (2) @(posedge clk_i);

    // Slave never responds: abort in the 8th stalled cycle.
    slv_mode = 1;
    exp_g.push_back(3'b100); exp_g.push_back(3'b000);
    exp_resp(3'b000, 3'b100, 1'b1, 1'b0, 32'h80, c_CTI_CLASSIC, 1'b1, 32'hC0DE0080);
    fork
      mxfer(2, 1'b1, 32'h80, 1, 0);
      begin
        int   c;
        logic seen;
        c = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk_i);
          if (grant_o != '0) c++;
          if (timeout_o) seen = 1'b1;
        end
        chk("tmo_cycles", 32'(c), 8);
      end
    join
    repeat (2) @(posedge clk_i);

    // Reset during beat 2 of an m2 burst, then m0 gets the first grant.
    slv_mode = 0; slv_lat = 0;
    exp_g.push_back(3'b100); exp_g.push_back(3'b000);
    exp_g.push_back(3'b001); exp_g.push_back(3'b000);
    exp_resp(3'b100, 3'b000, 1'b0, 1'b1, 32'h200, c_CTI_INCR, 1'b1, 32'hC0DE0200);
    exp_resp(3'b001, 3'b000, 1'b0, 1'b1, 32'h300, c_CTI_CLASSIC, 1'b1, 32'hC0DE0300);
    @(posedge clk_i); #1;
    m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_we_i[2] = 1'b1;
    adr_m[2] = 32'h200; dat_m[2] = 32'hC0DE0200; cti_m[2] = c_CTI_INCR;
    wait_ack(2, e);
    @(posedge clk_i); #1;
    adr_m[2] = 32'h204; dat_m[2] = 32'hC0DE0204;
    slv_mode = 1;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0; m_we_i[2] = 1'b0;
    @(negedge clk_i);
    chk("rstmid_s_cyc", 32'(s_cyc_o), 0);
    chk("rstmid_grant", 32'(grant_o), 0);
    chk("rstmid_ack",   32'(m_ack_o), 0);
    chk("rstmid_err",   32'(m_err_o), 0);
    slv_mode = 0; slv_lat = 1;
    mxfer(0, 1'b1, 32'h300, 1, 0);
    repeat (2) @(posedge clk_i);

    // m0 and m1 together with last=0: m0 priority, 4-beat burst holds the grant.
    slv_lat = 0;
    exp_g.push_back(3'b001); exp_g.push_back(3'b000);
    exp_g.push_back(3'b010); exp_g.push_back(3'b000);
    exp_resp(3'b001, 3'b000, 1'b0, 1'b1, 32'h100, c_CTI_INCR, 1'b1, 32'hC0DE0100);
    exp_resp(3'b001, 3'b000, 1'b0, 1'b1, 32'h104, c_CTI_INCR, 1'b1, 32'hC0DE0104);
    exp_resp(3'b001, 3'b000, 1'b0, 1'b1, 32'h108, c_CTI_INCR, 1'b1, 32'hC0DE0108);
    exp_resp(3'b001, 3'b000, 1'b0, 1'b1, 32'h10C, c_CTI_END,  1'b1, 32'hC0DE010C);
    exp_resp(3'b010, 3'b000, 1'b0, 1'b1, 32'h40,  c_CTI_CLASSIC, 1'b0, 32'hDEADBEAF);
    fork
      mxfer(0, 1'b1, 32'h100, 4, 0);
      mxfer(1, 1'b0, 32'h40, 1, 0);
    join
    repeat (2) @(posedge clk_i);

    // Slave err on m1 write; m1 keeps the grant while it holds cyc.
    slv_mode = 2; slv_lat = 1;
    exp_g.push_back(3'b010); exp_g.push_back(3'b000);
    exp_resp(3'b000, 3'b010, 1'b0, 1'b1, 32'h50, c_CTI_CLASSIC, 1'b1, 32'hC0DE0050);
    mxfer(1, 1'b1, 32'h50, 1, 3);
    slv_mode = 0;
    repeat (3) @(posedge clk_i);

    chk("grant_queue_left", 32'(exp_g.size()), 0);
    chk("resp_queue_left",  32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
